// File: rtl/rr_grant_sequencer.sv
// Round-robin arbiter for up to 32 requesters with registered index/one-hot grant,
// release-or-drop grant sequencing, a mandatory idle gap and a hold watchdog.
module rr_grant_sequencer #(
    parameter int unsigned N_REQ    = 32,
    parameter int unsigned IDX_W    = 5,
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             release_i,
    output logic             gnt_valid,
    output logic [IDX_W-1:0] gnt_idx,
    output logic [N_REQ-1:0] gnt_onehot,
    output logic             timeout
);

    localparam int unsigned HoldW = $clog2(MAX_HOLD);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e             state_q, state_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               valid_q, valid_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_REQ-1:0]   onehot_q, onehot_d;
    logic               timeout_q, timeout_d;

    logic               hi_found, lo_found;
    logic [IDX_W-1:0]   hi_idx, lo_idx, winner;
    logic               exit_rel, exit_drop, exit_hold;

    // Lowest set bit at or above ptr wins; otherwise wrap to the lowest set bit overall.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (req[j]) begin
                lo_found = 1'b1;
                lo_idx   = IDX_W'(j);
                if (IDX_W'(j) >= ptr_q) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(j);
                end
            end
        end
        winner = hi_found ? hi_idx : lo_idx;
    end

    assign exit_rel  = release_i;
    assign exit_drop = ~req[idx_q];
    assign exit_hold = (hold_q == HoldW'(MAX_HOLD - 1));

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        ptr_d     = ptr_q;
        valid_d   = valid_q;
        idx_d     = idx_q;
        onehot_d  = onehot_q;
        timeout_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                valid_d  = 1'b0;
                onehot_d = '0;
                if (lo_found) begin
                    state_d  = StGrant;
                    valid_d  = 1'b1;
                    idx_d    = winner;
                    onehot_d = N_REQ'(1) << winner;
                    hold_d   = '0;
                    ptr_d    = (winner == IDX_W'(N_REQ - 1)) ? '0 : winner + IDX_W'(1);
                end
            end
            StGrant: begin
                if (exit_rel || exit_drop || exit_hold) begin
                    state_d   = StIdle;
                    valid_d   = 1'b0;
                    onehot_d  = '0;
                    // Watchdog flag only when nothing else would have ended the grant.
                    timeout_d = exit_hold && !exit_rel && !exit_drop;
                end else begin
                    hold_d = hold_q + HoldW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= StIdle;
            hold_q    <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            onehot_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            ptr_q     <= ptr_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            onehot_q  <= onehot_d;
            timeout_q <= timeout_d;
        end
    end

    assign gnt_valid  = valid_q;
    assign gnt_idx    = idx_q;
    assign gnt_onehot = onehot_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_rr_grant_sequencer.sv
// Table-driven bench for rr_grant_sequencer: each vector's expected post-edge outputs
// go to a scoreboard queue when driven and are compared just after the next rising edge.
module tb_rr_grant_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req;
    logic        release_i;
    logic        gnt_valid;
    logic [4:0]  gnt_idx;
    logic [31:0] gnt_onehot;
    logic        timeout;

    rr_grant_sequencer #(
        .N_REQ   (32),
        .IDX_W   (5),
        .MAX_HOLD(16)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .release_i (release_i),
        .gnt_valid (gnt_valid),
        .gnt_idx   (gnt_idx),
        .gnt_onehot(gnt_onehot),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic [31:0] req;
        logic        rel;
        logic        valid;
        logic [4:0]  idx;
        logic        to;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_vec  = 0;

    function automatic vec_t mk(logic r, logic [31:0] q, logic rl, logic v, logic [4:0] i,
                                logic t);
        vec_t x;
        x.rst_n = r;
        x.req   = q;
        x.rel   = rl;
        x.valid = v;
        x.idx   = i;
        x.to    = t;
        return x;
    endfunction

    function automatic void add(logic r, logic [31:0] q, logic rl, logic v, logic [4:0] i,
                                logic t);
        vecs.push_back(mk(r, q, rl, v, i, t));
    endfunction

    function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s vec %0d got %h exp %h", name, n_vec, got, exp);
        end
    endfunction

    task automatic drive(input vec_t v);
        @(negedge clk);
        reset     = v.rst_n;
        req       = v.req;
        release_i = v.rel;
        sb.push_back(v);
    endtask

    always @(posedge clk) begin
        vec_t        e;
        logic [31:0] exp_oh;
        #1;
        if (sb.size() > 0) begin
            e      = sb.pop_front();
            exp_oh = e.valid ? (32'd1 << e.idx) : 32'd0;
            chk("gnt_valid", {31'd0, gnt_valid}, {31'd0, e.valid});
            chk("gnt_idx", {27'd0, gnt_idx}, {27'd0, e.idx});
            chk("gnt_onehot", gnt_onehot, exp_oh);
            chk("timeout", {31'd0, timeout}, {31'd0, e.to});
            chk("onehot_inv", gnt_onehot, gnt_valid ? (32'd1 << gnt_idx) : 32'd0);
            n_vec++;
        end
    end

    initial begin
        logic [31:0] m;
        logic [4:0]  g;
        reset     = 1'b0;
        req       = '0;
        release_i = 1'b0;

        // Reset state, then single requester 0 with 1-cycle latency.
        add(0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0);
        add(1, 32'h1, 0, 1, 0, 0);
        add(1, 32'h0, 0, 0, 0, 0);
        // release_i in IDLE with no requests is ignored.
        add(1, 32'h0, 1, 0, 0, 0);
        add(1, 32'h0, 0, 0, 0, 0);

        // All requesting, released on first grant cycle: 0..31 then wrap to 0.
        add(0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 32; i++) begin
            add(1, 32'hFFFF_FFFF, 0, 1, 5'(i % 32), 0);
            add(1, 32'hFFFF_FFFF, 1, 0, 5'(i % 32), 0);
        end

        // Watchdog: 3 and 30 alternate, 16 cycles each, timeout pulse after each.
        add(0, 0, 0, 0, 0, 0);
        m = (32'd1 << 3) | (32'd1 << 30);
        for (int r = 0; r < 3; r++) begin
            g = (r == 1) ? 5'd30 : 5'd3;
            for (int c = 0; c < 16; c++) add(1, m, 0, 1, g, 0);
            add(1, m, 0, 0, g, 1);
        end

        // Requester 7 drops after 4 grant cycles: no timeout.
        add(0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 4; c++) add(1, 32'd1 << 7, 0, 1, 7, 0);
        add(1, 32'h0, 0, 0, 7, 0);
        add(1, 32'h0, 0, 0, 7, 0);

        foreach (vecs[k]) drive(vecs[k]);

        // Reset mid-grant of 12, then 0 and 12 requesting: ptr restarts at 0.
        drive(mk(0, 0, 0, 0, 0, 0));
        drive(mk(1, 32'd1 << 12, 0, 1, 12, 0));
        drive(mk(1, 32'd1 << 12, 0, 1, 12, 0));
        drive(mk(0, 32'd1 << 12, 0, 0, 0, 0));
        drive(mk(1, (32'd1 << 12) | 32'd1, 0, 1, 0, 0));

        // Release coinciding with the last allowed hold cycle: no timeout.
        drive(mk(0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 16; c++) drive(mk(1, 32'd1 << 5, 0, 1, 5, 0));
        drive(mk(1, 32'd1 << 5, 1, 0, 5, 0));
        drive(mk(1, 32'd1 << 5, 0, 1, 5, 0));
        drive(mk(1, 32'h0, 0, 0, 5, 0));

        repeat (3) @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
